if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction fetch stage of the 5-stage pipeline.
- Owns the PC and drives the instruction-memory request/ready handshake.
- Registers if_pc / if_pc_plus4 / if_insn / if_en into the IF/ID boundary consumed by the decoder.
- Honours the stall, flush and branch-redirect controls, and holds a fetched word in a one-entry buffer while ID is stalled.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.
- NOP_INSN, 32'h0000_0013, instruction word driven on if_insn when a bubble is output (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold IF/ID outputs (load hazard / control stall).
- flush  in  1  kill the current fetch and redirect to new_pc.
- new_pc  in  32  flush target.
- br_taken  in  1  branch/jump resolved taken in ID.
- br_addr  in  32  branch target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= pc).
- imem_rd_data  in  32  fetched instruction; valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- if_pc  out  32  PC of the delivered instruction.
- if_pc_plus4  out  32  if_pc + 4.
- if_insn  out  32  delivered instruction.
- if_en  out  1  if_insn valid.
- fetch_cnt  out  32  count of delivered instructions (see Optional Feature).

Behaviour:
- Reset (reset=0 at posedge):
  - pc=RESET_VECTOR, state=IDLE.
  - if_pc=0, if_pc_plus4=0, if_insn=NOP_INSN, if_en=0.
  - buf cleared, redir cleared, fetch_cnt=0.
  - Reset asserted mid-operation aborts any state, including DRAIN and HOLD; any outstanding memory response is ignored.
- States: IDLE, FETCH, DRAIN, HOLD.
  - IDLE: imem_req=0. Next cycle goes to FETCH.
  - FETCH and DRAIN: imem_req=1, imem_addr=pc. The address is held stable until imem_ready=1.
  - HOLD: imem_req=0.
- Priority within a cycle: flush > br_taken > stall > normal. The target is new_pc if flush, else br_addr.
- Bubble: if_en=0 and if_insn=NOP_INSN. if_pc and if_pc_plus4 do not care (hold their values).
- Deliver: if_pc=P, if_pc_plus4=P+4 (32-bit wrap), if_insn=word, if_en=1.
- FETCH transitions:
  - Redirect with imem_ready=1: the response is discarded, pc=target, stay in FETCH, output a bubble.
  - Redirect with imem_ready=0: redir=target, go to DRAIN, output a bubble.
  - imem_ready=1 and stall=0: deliver (pc, imem_rd_data), pc=pc+4.
  - imem_ready=1 and stall=1: buf=imem_rd_data, buf_pc=pc, pc=pc+4, go to HOLD. IF/ID outputs hold.
  - imem_ready=0: stall=0 outputs a bubble; stall=1 holds the outputs.
- DRAIN:
  - Waits for the abandoned request to complete; its data is never delivered.
  - A new flush or br_taken overwrites redir (flush still wins).
  - imem_ready=1: pc=redir, go to FETCH.
  - Outputs a bubble unless stall=1, in which case outputs hold.
- HOLD:
  - Flush or br_taken: drop buf, pc=target, go to FETCH, output a bubble.
  - stall=0: deliver (buf_pc, buf), go to FETCH.
  - stall=1: remain.
- Flush or br_taken always force if_en=0 at the next edge, even when stall=1.
- Latency:
  - First instruction appears on if_en two cycles after reset deasserts, given a zero-wait memory.
  - Steady state: one instruction per cycle with imem_ready held at 1.
  - Redirect penalty: one bubble with a zero-wait memory.
- pc[1:0] is not checked; targets are used as given.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: fetch_cnt increments by 1 at every edge where if_en is written to 1 (each deliver). It wraps at 2^32 and resets to 0.
- Undefined: fetch_cnt is tied to 32'h0 and no counter flops are built.

Test Plan:
- Release reset, imem_ready=1, memory returns word=addr^32'hA5A5_0000 → if_pc 0,4,8 on consecutive cycles, first if_en=1 two cycles after release, if_pc_plus4 = if_pc+4.
- Stall=1 for 2 cycles while imem_ready=1 with pc=0x10 → if outputs hold the 0xC instruction; HOLD buffers 0x10; on stall=0, 0x10 is delivered, then 0x14; no instruction lost or duplicated.
- br_taken=1, br_addr=0x100 during FETCH with imem_ready=1 → next cycle if_en=0 / if_insn=0x13, then imem_addr=0x100, next delivered if_pc=0x100.
- br_taken to 0x200 while imem_ready=0 (wait 3 cycles) → DRAIN, imem_addr stays at the old pc until ready, old data never delivered, then fetch from 0x200.
- flush=1 with new_pc=0x80 and br_taken=1 with br_addr=0x40 in the same cycle, stall=1 → flush wins, if_en=0, next fetch address 0x80.
- IF_PERF_CNT_EN defined, 5 delivers, then a 2-cycle stall and 1 bubble → fetch_cnt=5; reset mid-DRAIN → fetch_cnt=0, imem_addr=RESET_VECTOR after IDLE.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage of the 5-stage pipeline.
//
// Owns the PC, drives the instruction-memory request/ready handshake and
// registers the IF/ID boundary (if_pc / if_pc_plus4 / if_insn / if_en).
// Handles stall, flush and branch redirect, and keeps a one-entry buffer
// for a word that returns while ID is stalled.
//
// Optional feature: define IF_PERF_CNT_EN to build the delivered-instruction
// counter on fetch_cnt_o; otherwise fetch_cnt_o is tied to zero.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-low reset
//   stall_i          hold IF/ID outputs
//   flush_i          kill current fetch, redirect to new_pc_i (beats br_taken_i)
//   new_pc_i         flush target
//   br_taken_i       branch/jump resolved taken in ID
//   br_addr_i        branch target
//   imem_req_o       fetch request valid
//   imem_addr_o      fetch address (= pc)
//   imem_rd_data_i   fetched word, valid when imem_ready_i=1
//   imem_ready_i     memory completes the current request this cycle
//   if_pc_o          PC of the delivered instruction
//   if_pc_plus4_o    if_pc_o + 4
//   if_insn_o        delivered instruction (NOP_INSN on a bubble)
//   if_en_o          if_insn_o valid
//   fetch_cnt_o      count of delivered instructions
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd_data_i,
  input  logic        imem_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [31:0] if_insn_o,
  output logic        if_en_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHold} state_e;
  typedef enum logic [1:0] {OutHold, OutBubble, OutDeliver} out_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0] if_insn_q, if_insn_d;
  logic        if_en_q, if_en_d;

  out_e        out_act;
  out_e        idle_out;
  logic [31:0] del_pc;
  logic [31:0] del_insn;
  logic        redirect;
  logic [31:0] target;

  assign redirect = flush_i | br_taken_i;
  assign target   = flush_i ? new_pc_i : br_addr_i;
  // With no redirect, a stall keeps ID's current instruction; otherwise a bubble.
  assign idle_out = stall_i ? OutHold : OutBubble;

  // Next-state and IF/ID action selection
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    buf_d    = buf_q;
    buf_pc_d = buf_pc_q;
    out_act  = OutHold;
    del_pc   = pc_q;
    del_insn = imem_rd_data_i;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        out_act = OutBubble;
        if (redirect) pc_d = target;
      end
      StFetch: begin
        if (redirect) begin
          out_act = OutBubble;
          if (imem_ready_i) begin
            pc_d = target;
          end else begin
            // Request already issued; let it complete before moving the address.
            redir_d = target;
            state_d = StDrain;
          end
        end else if (imem_ready_i) begin
          pc_d = pc_q + 32'd4;
          if (stall_i) begin
            buf_d    = imem_rd_data_i;
            buf_pc_d = pc_q;
            state_d  = StHold;
            out_act  = OutHold;
          end else begin
            out_act = OutDeliver;
          end
        end else begin
          out_act = idle_out;
        end
      end
      StDrain: begin
        out_act = redirect ? OutBubble : idle_out;
        if (redirect) redir_d = target;
        if (imem_ready_i) begin
          pc_d    = redirect ? target : redir_q;
          state_d = StFetch;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StFetch;
          out_act = OutBubble;
        end else if (!stall_i) begin
          del_pc   = buf_pc_q;
          del_insn = buf_q;
          state_d  = StFetch;
          out_act  = OutDeliver;
        end else begin
          out_act = OutHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // IF/ID boundary next values
  always_comb begin
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_insn_d     = if_insn_q;
    if_en_d       = if_en_q;
    unique case (out_act)
      OutBubble: begin
        if_insn_d = NOP_INSN;
        if_en_d   = 1'b0;
      end
      OutDeliver: begin
        if_pc_d       = del_pc;
        if_pc_plus4_d = del_pc + 32'd4;
        if_insn_d     = del_insn;
        if_en_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VECTOR;
      redir_q       <= 32'h0;
      buf_q         <= 32'h0;
      buf_pc_q      <= 32'h0;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      if_insn_q     <= NOP_INSN;
      if_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_q       <= redir_d;
      buf_q         <= buf_d;
      buf_pc_q      <= buf_pc_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_insn_q     <= if_insn_d;
      if_en_q       <= if_en_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 32'h0;
    end else if (out_act == OutDeliver) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
  assign fetch_cnt_o = cnt_q;
`else
  assign fetch_cnt_o = 32'h0;
`endif

  assign imem_req_o    = (state_q == StFetch) || (state_q == StDrain);
  assign imem_addr_o   = pc_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc_plus4_o = if_pc_plus4_q;
  assign if_insn_o     = if_insn_q;
  assign if_en_o       = if_en_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a scoreboard of expected delivered PCs.
// Memory returns addr ^ 32'hA5A5_0000 combinationally whenever ready is set.
module tb_if_stage;

`ifdef IF_PERF_CNT_EN
  localparam logic [31:0] CntOn = 32'd1;
`else
  localparam logic [31:0] CntOn = 32'd0;
`endif
  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, br_taken, imem_ready;
  logic [31:0] new_pc, br_addr;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rd_data;
  logic [31:0] if_pc, if_pc_plus4, if_insn, fetch_cnt;
  logic        if_en;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic stall_e = 1'b0;
  logic rst_e   = 1'b0;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall),
    .flush_i        (flush),
    .new_pc_i       (new_pc),
    .br_taken_i     (br_taken),
    .br_addr_i      (br_addr),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_rd_data_i (imem_rd_data),
    .imem_ready_i   (imem_ready),
    .if_pc_o        (if_pc),
    .if_pc_plus4_o  (if_pc_plus4),
    .if_insn_o      (if_insn),
    .if_en_o        (if_en),
    .fetch_cnt_o    (fetch_cnt)
  );

  always #5 clk = ~clk;

  assign imem_rd_data = imem_addr ^ Key;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a new delivery is if_en=1 after an edge where reset was released
  // and stall was low (a stalled edge only holds the previous delivery).
  always @(posedge clk) begin
    stall_e <= stall;
    rst_e   <= reset;
  end

  always @(negedge clk) begin
    logic [31:0] p;
    if (rst_e && !stall_e && if_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got pc %h, expected none", if_pc);
      end else begin
        p = exp_q.pop_front();
        chk("deliver_pc", if_pc, p);
        chk("deliver_pc4", if_pc_plus4, p + 32'd4);
        chk("deliver_insn", if_insn, p ^ Key);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = 32'h0; br_addr = 32'h0; imem_ready = 1'b1;
    repeat (3) tick();
    chk("rst_if_en", {31'h0, if_en}, 32'h0);
    chk("rst_if_insn", if_insn, Nop);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc4", if_pc_plus4, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);

    // Streaming from reset
    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
    exp_q.push_back(32'h0C); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    reset = 1'b1;
    tick();  // IDLE -> FETCH
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_no_en", {31'h0, if_en}, 32'h0);
    repeat (4) tick();  // deliver 0,4,8,C
    chk("pre_stall_addr", imem_addr, 32'h10);

    // Stall two cycles while memory is ready at 0x10
    stall = 1'b1;
    tick();
    chk("hold1_pc", if_pc, 32'h0C);
    chk("hold1_en", {31'h0, if_en}, 32'h1);
    chk("hold1_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("hold2_pc", if_pc, 32'h0C);
    chk("hold2_insn", if_insn, 32'h0C ^ Key);
    chk("hold_cnt", fetch_cnt, 32'd4 * CntOn);
    stall = 1'b0;
    tick();  // 0x10 from buffer
    tick();  // 0x14
    chk("post_stall_cnt", fetch_cnt, 32'd6 * CntOn);

    // Taken branch with zero-wait memory
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    br_taken = 1'b1; br_addr = 32'h100;
    tick();
    chk("br_bubble_en", {31'h0, if_en}, 32'h0);
    chk("br_bubble_insn", if_insn, Nop);
    chk("br_addr", imem_addr, 32'h100);
    br_taken = 1'b0;
    repeat (2) tick();

    // Branch while the current request is outstanding
    exp_q.push_back(32'h200);
    br_taken = 1'b1; br_addr = 32'h200; imem_ready = 1'b0;
    tick();
    br_taken = 1'b0;
    chk("drain_en", {31'h0, if_en}, 32'h0);
    chk("drain_req", {31'h0, imem_req}, 32'h1);
    chk("drain_addr0", imem_addr, 32'h108);
    tick();
    chk("drain_addr1", imem_addr, 32'h108);
    tick();
    chk("drain_addr2", imem_addr, 32'h108);
    imem_ready = 1'b1;
    tick();
    chk("drain_done_addr", imem_addr, 32'h200);
    chk("drain_done_en", {31'h0, if_en}, 32'h0);
    tick();  // 0x200

    // Flush and branch together under stall: flush wins
    exp_q.push_back(32'h80); exp_q.push_back(32'h84);
    flush = 1'b1; new_pc = 32'h80; br_taken = 1'b1; br_addr = 32'h40; stall = 1'b1;
    tick();
    chk("flush_en", {31'h0, if_en}, 32'h0);
    chk("flush_addr", imem_addr, 32'h80);
    flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
    repeat (2) tick();

    // Stall with no response holds; then branch into DRAIN, flush overrides redir
    imem_ready = 1'b0; stall = 1'b1;
    tick();
    chk("wait_hold_en", {31'h0, if_en}, 32'h1);
    chk("wait_hold_pc", if_pc, 32'h84);
    chk("wait_cnt", fetch_cnt, 32'd11 * CntOn);
    stall = 1'b0; br_taken = 1'b1; br_addr = 32'h300;
    tick();
    chk("drain2_en", {31'h0, if_en}, 32'h0);
    br_taken = 1'b0; flush = 1'b1; new_pc = 32'h400;
    tick();
    flush = 1'b0; imem_ready = 1'b1;
    exp_q.push_back(32'h400);
    tick();
    chk("redir_override_addr", imem_addr, 32'h400);
    tick();  // 0x400
    chk("cnt12", fetch_cnt, 32'd12 * CntOn);

    // Reset in the middle of DRAIN
    br_taken = 1'b1; br_addr = 32'h500; imem_ready = 1'b0;
    tick();
    chk("drain3_addr", imem_addr, 32'h404);
    reset = 1'b0; br_taken = 1'b0; imem_ready = 1'b1;
    tick();
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_en", {31'h0, if_en}, 32'h0);
    chk("mid_rst_cnt", fetch_cnt, 32'h0);
    exp_q.push_back(32'h0);
    reset = 1'b1;
    tick();
    chk("rerun_addr", imem_addr, 32'h0);
    chk("rerun_req", {31'h0, imem_req}, 32'h1);
    tick();  // 0x0 again
    imem_ready = 1'b0;
    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
